output_unit_display: RTL and testbench
======================================

// Module: output_unit_display
// PURPOSE
//   Display side of the calculator: counterpart of the keypad input path. Latches an 8-bit
//   two's-complement result on load, converts it sequentially (shift-add-3) to sign + 3 BCD
//   digits, and drives a 4-digit multiplexed 7-segment display. Shows either the live keypad
//   digit buffer (16-bit BCD, nibble 4'hF = blank) or the latched result, or "Err" on overflow.
// PARAMETERS
//   REFRESH_DIV   50000  clk cycles each digit stays enabled per scan step (>=2)
//   SEG_ACT_LOW   1      1: seg/an outputs active-low; 0: active-high
// PORTS
//   clk         in   1   system clock, all state on rising edge
//   reset       in   1   asynchronous, active-low reset
//   load        in   1   1-cycle strobe: capture value/ovf, start conversion
//   value       in   8   result, two's complement (-128..127)
//   ovf         in   1   result invalid/overflow; captured with value
//   show_result in   1   1: display latched result; 0: display BCD_I
//   BCD_I       in   16  keypad digit buffer, digit3..digit0 MS-first, 4'hF = blank
//   seg         out  7   segments {g,f,e,d,c,b,a}
//   an          out  4   digit enables, an[3] = leftmost
//   busy        out  1   conversion in progress
//   ready       out  1   latched result valid for display
// BEHAVIOUR
//   Reset (reset=0, async): FSM=IDLE, ready=0, busy=0, scan index=0, divider=0, result
//     registers cleared; seg = all off, an = all off (polarity per SEG_ACT_LOW) until released.
//   FSM IDLE -> CONV on load; CONV runs exactly 8 shift steps; CONV -> DONE -> IDLE.
//     Cycle of load = 0: value/ovf latched, magnitude = |value| (9-bit; -128 -> 128), busy=1,
//     ready=0. Cycles 1..8: one shift-add-3 step each. Cycle 9: DONE, BCD committed,
//     busy=0, ready=1 from cycle 10. Latency load->ready = 10 cycles.
//   load while CONV/DONE: abort, relatch, restart from cycle 0 (last load wins).
//   ready stays 1 until next load or reset; display shows old result only if ready=1.
//   Result glyphs (digit3..0): ovf=1 -> blank,'E','r','r'. Else digit3 = '-' if value[7]
//     else blank; hundreds/tens/ones with leading-zero blanking; ones digit always shown
//     (0 -> "   0", -128 -> "-128", -5 -> "  -5": minus sits left of first shown digit).
//   show_result=1 and ready=0 -> all four digits blank (never show partial conversion).
//   show_result=0: digits from BCD_I; nibble 4'hF blank, 4'hA..4'hE also blank.
//   show_result may change any cycle; takes effect on the next displayed digit refresh.
//   Scan: divider counts 0..REFRESH_DIV-1; on wrap, index 3->2->1->0->3 (decrement, wraps).
//     Exactly one an bit active at all times after reset; seg/an registered together so
//     no ghosting cycle where an and seg disagree.
// STRUCTURE
//   Package calc_disp_pkg: 5-bit glyph codes (G_0..G_9, G_BLANK, G_MINUS, G_E, G_R),
//     glyph->7-seg constant table, FSM state enum {IDLE, CONV, DONE}.
//   Sub-module bin2bcd_seq: 8-step sequential double-dabble, ports start/mag[7:0]/done/bcd[11:0];
//     top holds FSM glue, sign/blanking glyph mux, refresh divider and scan registers.
// TESTING
//   load value=8'h7F -> ready rises exactly 10 cycles later, digits " 127" on scan.
//   load value=8'h80 -> "-128"; load 8'hFB -> "  -5"; load 8'h00 -> "   0".
//   load with ovf=1 -> " Err" regardless of value; ready=1.
//   second load at cycle 4 of a conversion -> only second value displayed, ready at +10 from it.
//   show_result=0, BCD_I=16'hF12F -> " 12 "; show_result=1 before any load -> all blank.
//   reset asserted mid-CONV -> seg/an off immediately (async), ready=0; REFRESH_DIV=4: an
//     steps every 4 cycles, one-hot, order 3,2,1,0,3.

Source files
------------

// File: rtl/calc_disp_pkg.sv
// Shared types for the calculator display path: glyph codes, segment table and
// the conversion FSM state encoding.
package calc_disp_pkg;

    typedef enum logic [4:0] {
        G_0     = 5'd0,
        G_1     = 5'd1,
        G_2     = 5'd2,
        G_3     = 5'd3,
        G_4     = 5'd4,
        G_5     = 5'd5,
        G_6     = 5'd6,
        G_7     = 5'd7,
        G_8     = 5'd8,
        G_9     = 5'd9,
        G_BLANK = 5'd10,
        G_MINUS = 5'd11,
        G_E     = 5'd12,
        G_R     = 5'd13
    } glyph_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CONV_STEPS = 8;

    // Active-high segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph_seg(input glyph_t g);
        logic [6:0] s;
        case (g)
            G_0:     s = 7'h3F;
            G_1:     s = 7'h06;
            G_2:     s = 7'h5B;
            G_3:     s = 7'h4F;
            G_4:     s = 7'h66;
            G_5:     s = 7'h6D;
            G_6:     s = 7'h7D;
            G_7:     s = 7'h07;
            G_8:     s = 7'h7F;
            G_9:     s = 7'h6F;
            G_MINUS: s = 7'h40;
            G_E:     s = 7'h79;
            G_R:     s = 7'h50;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Decimal nibbles map to their digit; any other code is shown blank.
    function automatic glyph_t digit_glyph(input logic [3:0] d);
        glyph_t g;
        if (d <= 4'd9) begin
            g = glyph_t'({1'b0, d});
        end else begin
            g = G_BLANK;
        end
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: converts an 8-bit magnitude to three BCD digits in
// CONV_STEPS shift steps after start; done pulses for one cycle at the end.
module bin2bcd_seq
    import calc_disp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  mag,
    output logic        done,
    output logic [11:0] bcd
);

    // {hundreds, tens, ones, binary}; the binary part drains into the BCD part.
    logic [19:0] sr;
    logic [19:0] sr_adj;
    logic [2:0]  step;
    logic        active;

    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < 3; i++) begin
            if (sr[8 + 4*i +: 4] >= 4'd5) begin
                sr_adj[8 + 4*i +: 4] = sr[8 + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr     <= '0;
            step   <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr     <= {12'd0, mag};
                step   <= '0;
                active <= 1'b1;
            end else if (active) begin
                sr   <= {sr_adj[18:0], 1'b0};
                step <= step + 3'd1;
                if (step == 3'(CONV_STEPS - 1)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    assign bcd = sr[19:8];

endmodule

// File: rtl/output_unit_display.sv
// Calculator display: latches a signed result, converts it to sign + BCD and
// scans either that result or the keypad buffer onto a 4-digit 7-segment display.
module output_unit_display
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  value,
    input  logic        ovf,
    input  logic        show_result,
    input  logic [15:0] BCD_I,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        busy,
    output logic        ready,
    output state_t      dbg_state
);

    localparam int         DIV_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_OFF  = SEG_ACT_LOW ? 4'hF : 4'h0;

    state_t      state;
    state_t      state_next;
    logic        sign_q;
    logic        ovf_q;
    logic [11:0] bcd_q;
    logic [7:0]  mag;
    logic        conv_done;
    logic [11:0] conv_bcd;

    logic [DIV_W-1:0] div;
    logic [1:0]       idx;
    glyph_t           res_g [4];
    glyph_t           cur_g;
    logic [3:0]       hund;
    logic [3:0]       tens;
    logic [3:0]       ones;

    // Two's-complement magnitude; -128 yields 8'h80 which is exactly 128.
    assign mag = value[7] ? (~value + 8'd1) : value;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (load),
        .mag   (mag),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        state_next = state;
        if (load) begin
            state_next = CONV;
        end else begin
            case (state)
                CONV:    if (conv_done) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            sign_q <= 1'b0;
            ovf_q  <= 1'b0;
            bcd_q  <= '0;
            busy   <= 1'b0;
            ready  <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                sign_q <= value[7];
                ovf_q  <= ovf;
                busy   <= 1'b1;
                ready  <= 1'b0;
            end else if (state == CONV && conv_done) begin
                bcd_q <= conv_bcd;
                busy  <= 1'b0;
            end else if (state == DONE) begin
                ready <= 1'b1;
            end
        end
    end

    assign dbg_state = state;

    assign hund = bcd_q[11:8];
    assign tens = bcd_q[7:4];
    assign ones = bcd_q[3:0];

    // Result glyphs with leading-zero blanking; the minus hugs the first shown digit.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            res_g[i] = G_BLANK;
        end
        if (ovf_q) begin
            res_g[2] = G_E;
            res_g[1] = G_R;
            res_g[0] = G_R;
        end else begin
            res_g[0] = digit_glyph(ones);
            if (hund != 4'd0) begin
                res_g[2] = digit_glyph(hund);
                res_g[1] = digit_glyph(tens);
            end else if (tens != 4'd0) begin
                res_g[1] = digit_glyph(tens);
            end
            if (sign_q) begin
                if (hund != 4'd0) begin
                    res_g[3] = G_MINUS;
                end else if (tens != 4'd0) begin
                    res_g[2] = G_MINUS;
                end else begin
                    res_g[1] = G_MINUS;
                end
            end
        end
    end

    always_comb begin
        cur_g = G_BLANK;
        if (show_result) begin
            if (ready) begin
                cur_g = res_g[idx];
            end
        end else begin
            cur_g = digit_glyph(BCD_I[{idx, 2'b00} +: 4]);
        end
    end

    // seg and an come from the same idx on the same edge, so they never disagree.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= '0;
            idx <= 2'd0;
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            if (div == DIV_W'(REFRESH_DIV - 1)) begin
                div <= '0;
                idx <= idx - 2'd1;
            end else begin
                div <= div + 1'b1;
            end
            seg <= glyph_seg(cur_g) ^ SEG_OFF;
            an  <= (4'b0001 << idx) ^ AN_OFF;
        end
    end

endmodule

// File: tb/tb_output_unit_display.sv
// Randomized scoreboard bench for output_unit_display with a fast refresh divider.
module tb_output_unit_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  value = 8'h00;
    logic        ovf = 1'b0;
    logic        show_result = 1'b1;
    logic [15:0] bcd_i = 16'hFFFF;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        busy;
    logic        ready;
    calc_disp_pkg::state_t dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int k = 0;
    bit mon_busy = 1'b0;

    logic [27:0] exp_q [$];
    int          lat_q [$];

    output_unit_display #(.REFRESH_DIV(DIV), .SEG_ACT_LOW(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .value       (value),
        .ovf         (ovf),
        .show_result (show_result),
        .BCD_I       (bcd_i),
        .seg         (seg),
        .an          (an),
        .busy        (busy),
        .ready       (ready),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset) k = 0;
        else        k = k + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Active-low segment image of one display character.
    function automatic logic [6:0] seg_of(input byte c);
        logic [6:0] s;
        case (c)
            "0": s = 7'h3F;
            "1": s = 7'h06;
            "2": s = 7'h5B;
            "3": s = 7'h4F;
            "4": s = 7'h66;
            "5": s = 7'h6D;
            "6": s = 7'h7D;
            "7": s = 7'h07;
            "8": s = 7'h7F;
            "9": s = 7'h6F;
            "-": s = 7'h40;
            "E": s = 7'h79;
            "r": s = 7'h50;
            default: s = 7'h00;
        endcase
        return ~s;
    endfunction

    // s[0] is the leftmost character, shown on an[3].
    function automatic logic [27:0] str2seg(input string s);
        logic [27:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[(3 - i) * 7 +: 7] = seg_of(s[i]);
        end
        return r;
    endfunction

    function automatic logic [27:0] exp_result(input logic [7:0] v, input logic o);
        string s;
        int    sv;
        if (o) begin
            s = " Err";
        end else begin
            sv = $signed(v);
            s = $sformatf("%0d", sv);
            while (s.len() < 4) s = {" ", s};
        end
        return str2seg(s);
    endfunction

    function automatic logic [27:0] exp_buf(input logic [15:0] b);
        string s;
        int    n;
        s = "";
        for (int i = 3; i >= 0; i--) begin
            n = int'((b >> (4 * i)) & 16'hF);
            if (n <= 9) s = {s, $sformatf("%0d", n)};
            else        s = {s, " "};
        end
        return str2seg(s);
    endfunction

    // Samples one full scan and assembles the four digit images by an position.
    task automatic collect(output logic [27:0] got);
        got = '0;
        repeat (2) @(negedge clk);
        repeat (4 * DIV) begin
            @(negedge clk);
            case (an)
                4'b1110: got[6:0]   = seg;
                4'b1101: got[13:7]  = seg;
                4'b1011: got[20:14] = seg;
                4'b0111: got[27:21] = seg;
                default: ;
            endcase
        end
    endtask

    task automatic disp_check(input string name, input logic [27:0] e);
        logic [27:0] got;
        collect(got);
        check(name, got, e);
    endtask

    // A load issued while a result is still pending supersedes it.
    task automatic do_load(input logic [7:0] v, input logic o);
        @(negedge clk);
        value = v;
        ovf   = o;
        load  = 1'b1;
        if (exp_q.size() != 0) begin
            void'(exp_q.pop_back());
            void'(lat_q.pop_back());
        end
        exp_q.push_back(exp_result(v, o));
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        lat_q.push_back(cyc);
        check("busy_after_load", busy, 1'b1);
        check("ready_after_load", ready, 1'b0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 80) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", (exp_q.size() != 0 || mon_busy), 1'b0);
        if (exp_q.size() != 0) begin
            exp_q.delete();
            lat_q.delete();
        end
    endtask

    task automatic load_abort(input logic [7:0] v0, input logic [7:0] v1, input logic o1, input int gap);
        do_load(v0, 1'b0);
        repeat (gap - 2) @(negedge clk);
        do_load(v1, o1);
        wait_idle();
    endtask

    // Monitor: each rising ready must match the oldest pending result.
    initial begin
        logic        prev;
        logic [27:0] e;
        logic [27:0] got;
        int          lc;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev = 1'b0;
            end else begin
                if (ready && !prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready got=1 expected=0 (cycle %0d)", cyc);
                    end else begin
                        mon_busy = 1'b1;
                        e  = exp_q.pop_front();
                        lc = lat_q.pop_front();
                        check("load_to_ready_latency", cyc - lc, 10);
                        check("busy_at_ready", busy, 1'b0);
                        collect(got);
                        check("result_display", got, e);
                        mon_busy = 1'b0;
                    end
                end
                prev = ready;
            end
        end
    end

    // Scan order: index starts at 0 and decrements every DIV cycles.
    always @(negedge clk) begin
        int         idx;
        logic [3:0] ea;
        if (reset && k >= 1) begin
            idx = (4 - ((k - 1) / DIV) % 4) % 4;
            ea  = ~(4'b0001 << idx);
            check("scan_an", an, ea);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  v;
        logic        o;
        logic [15:0] b;

        repeat (3) @(negedge clk);
        check("rst_seg", seg, 7'h7F);
        check("rst_an", an, 4'hF);
        check("rst_ready", ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", dbg_state, calc_disp_pkg::IDLE);
        reset = 1'b1;

        disp_check("blank_before_load", str2seg("    "));

        do_load(8'h7F, 1'b0); wait_idle();
        do_load(8'h80, 1'b0); wait_idle();
        do_load(8'hFB, 1'b0); wait_idle();
        do_load(8'h00, 1'b0); wait_idle();
        do_load(8'hF4, 1'b0); wait_idle();
        do_load(8'h55, 1'b1); wait_idle();

        load_abort(8'h12, 8'hC8, 1'b0, 4);

        show_result = 1'b0;
        bcd_i = 16'hF12F;
        disp_check("buf_f12f", exp_buf(bcd_i));
        for (int i = 0; i < 4; i++) begin
            b = 16'($urandom_range(0, 65535));
            bcd_i = b;
            disp_check("buf_random", exp_buf(b));
        end
        show_result = 1'b1;
        disp_check("result_after_buf", exp_result(8'hC8, 1'b0));

        for (int i = 0; i < 12; i++) begin
            v = 8'($urandom_range(0, 255));
            o = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) == 0) begin
                load_abort(8'($urandom_range(0, 255)), v, o, int'($urandom_range(2, 8)));
            end else begin
                do_load(v, o);
                wait_idle();
            end
        end

        do_load(8'h33, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midconv_rst_seg", seg, 7'h7F);
        check("midconv_rst_an", an, 4'hF);
        check("midconv_rst_ready", ready, 1'b0);
        check("midconv_rst_busy", busy, 1'b0);
        exp_q.delete();
        lat_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        disp_check("blank_after_reset", str2seg("    "));
        do_load(8'hFF, 1'b0); wait_idle();

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
